piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out transmitter: the sending end of the serial-in shift-register link.
//   Accepts a WIDTH-bit word via a valid/ready load handshake and emits it one bit per clock, MSB first.
//   After WIDTH shifts, a 4-bit SIPO (which shifts din into its LSB) holds the original word.
//   Sits between a word producer and a 1-bit serial line.
// PARAMETERS
//   WIDTH   4   word length in bits (>= 2)
// PORTS
//   clk         in   1      clock; all logic on posedge
//   rst         in   1      synchronous, active-high reset
//   load_valid  in   1      producer offers load_data
//   load_data   in   WIDTH  word to transmit; sampled only at handshake
//   load_ready  out  1      block can accept a word this cycle
//   sout        out  1      serial data bit
//   sout_valid  out  1      sout carries a frame bit this cycle
//   busy        out  1      frame in progress (state SHIFT)
//   done        out  1      1-cycle pulse, coincident with last frame bit
// BEHAVIOUR
//   - Reset (synchronous, active-high): state=IDLE; sout=0, sout_valid=0, busy=0, done=0; shift reg and counter=0.
//     rst=1 at an edge aborts any frame; the partial frame is discarded; no done pulse.
//   - States: IDLE, SHIFT. All outputs except load_ready are registered.
//   - load_ready: 1 in IDLE; 1 in SHIFT only on the last frame-bit cycle; else 0.
//   - Handshake: load_valid & load_ready at an edge -> capture load_data, go/stay SHIFT, cnt=0.
//     First bit (MSB) appears on sout in the cycle after the handshake edge (latency 1).
//   - SHIFT: sout=current bit, sout_valid=1, busy=1; each edge shifts left by one and increments cnt.
//   - Last bit (cnt==FRAME_LEN-1): done=1.
//     If a handshake occurs at that edge, the next word's MSB follows with no gap; else go IDLE, outputs return to 0.
//   - load_valid while load_ready=0: ignored; load_data is not sampled; producer must hold.
//   - FRAME_LEN = WIDTH (WIDTH+1 with parity). cnt width = $clog2(FRAME_LEN+1); no wrap beyond FRAME_LEN-1.
//   - sout=0 whenever sout_valid=0.
// CONFIGURATION
//   PISO_PARITY_EN defined: append even-parity bit (^word) after the LSB.
//     FRAME_LEN=WIDTH+1; done and load_ready fire on the parity cycle.
//   PISO_PARITY_EN undefined: no parity logic; FRAME_LEN=WIDTH.
// STRUCTURE
//   Package piso_pkg: state_t enum {IDLE, SHIFT}; FRAME_LEN/CNT_W derivation function.
//   Sub-module piso_bit_counter: frame bit counter.
//     Inputs: clear, enable. Outputs: last flag at FRAME_LEN-1.
//   Top module holds the FSM, shift register, parity and output registers.
// TESTING (WIDTH=4, parity off unless stated)
//   1 rst=1 two cycles, load_valid=1 -> sout=0, sout_valid=0, busy=0, done=0, load_ready=1; no capture.
//   2 load 4'b1011 -> sout 1,0,1,1 on the 4 following cycles; sout_valid=1 for exactly 4 cycles.
//     done only on 4th; then IDLE.
//   3 back-to-back 4'b1010 then 4'b0110 (2nd offered on last-bit cycle) -> 8 contiguous bits 1,0,1,0,0,1,1,0.
//     done pulses on cycles 4 and 8.
//   4 load 4'b1100, then load_valid=1 with 4'b0011 during bits 1-3
//     -> ignored until last-bit cycle, accepted there; first frame unchanged.
//   5 load 4'b1111; rst=1 after bit 2 -> next cycle all outputs 0, no done; new load 4'b0101 serializes correctly.
//   6 loopback into 4-bit SIPO (din=sout, shift on sout_valid) for 4'b1011 -> SIPO holds 4'b1011 after done.
//     With PISO_PARITY_EN: 5th bit=1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and frame geometry for the parallel-in serial-out transmitter.
// Defining PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_t;

`ifdef PISO_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  // Bits on the wire per word: data plus the optional parity bit.
  function automatic int unsigned frame_len(input int unsigned width);
    return ParityEn ? width + 1 : width;
  endfunction

  // The counter holds 0..FrameLen-1 but is sized for FrameLen to leave headroom.
  function automatic int unsigned cnt_w(input int unsigned width);
    return int'($clog2(frame_len(width) + 1));
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared at each word load, advanced once per shifted bit,
// saturating at the last frame bit so it never wraps.
module piso_bit_counter #(
  parameter int unsigned FrameLen = 4,
  parameter int unsigned CntW     = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last,
  output logic becomes_last
);

  localparam logic [CntW-1:0] LastIdx   = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] PenultIdx = CntW'(FrameLen - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !last) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LastIdx);
  // Lets the owner register a flag that lines up with the last bit.
  assign becomes_last = enable && !clear && (cnt_q == PenultIdx);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first serial output.
// Build option PISO_PARITY_EN appends an even-parity bit after the LSB of each word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FrameLen = frame_len(WIDTH);
  localparam int unsigned CntW     = cnt_w(WIDTH);

  state_t state_q, state_d;
  logic [FrameLen-1:0] frame_q, frame_d, frame_load;
  logic handshake;
  logic cnt_clear, cnt_enable, cnt_last, cnt_becomes_last;
  logic sout_d, sout_valid_d, busy_d, done_d;

`ifdef PISO_PARITY_EN
  assign frame_load = {load_data, ^load_data};
`else
  assign frame_load = load_data;
`endif

  assign load_ready = (state_q == StIdle) || ((state_q == StShift) && cnt_last);
  assign handshake  = load_valid && load_ready;

  piso_bit_counter #(
    .FrameLen (FrameLen),
    .CntW     (CntW)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clear),
    .enable       (cnt_enable),
    .last         (cnt_last),
    .becomes_last (cnt_becomes_last)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          state_d   = StShift;
          frame_d   = frame_load;
          cnt_clear = 1'b1;
        end
      end
      StShift: begin
        if (cnt_last) begin
          cnt_clear = 1'b1;
          // A word accepted on the last bit follows with no idle gap.
          if (handshake) begin
            frame_d = frame_load;
          end else begin
            state_d = StIdle;
            frame_d = '0;
          end
        end else begin
          frame_d    = frame_q << 1;
          cnt_enable = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        frame_d = '0;
      end
    endcase

    // Outputs are registered from next-state so they align with the frame bit they describe.
    busy_d       = (state_d == StShift);
    sout_valid_d = busy_d;
    sout_d       = busy_d && frame_d[FrameLen-1];
    done_d       = cnt_becomes_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      sout       <= sout_d;
      sout_valid <= sout_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: frame bits are queued at each accepted load
// and checked one per cycle against sout/sout_valid/done/busy/load_ready.
module tb_piso_serializer;

  localparam int unsigned Width = 4;
`ifdef PISO_PARITY_EN
  localparam int unsigned FrameLen = Width + 1;
`else
  localparam int unsigned FrameLen = Width;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic [Width-1:0] load_data;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  exp_t        q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        mon_en  = 1'b0;
  logic [7:0]  sipo;
  int unsigned n_valid;
  int unsigned n_done;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH (Width)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: the queue head is the bit that must be on the line this cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      check("load_ready", 32'(load_ready), 32'(q.size() <= 1));
      check("sout_valid", 32'(sout_valid), 32'(q.size() != 0));
      check("busy", 32'(busy), 32'(q.size() != 0));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sout", 32'(sout), 32'(e.b));
        check("done", 32'(done), 32'(e.last));
      end else begin
        check("sout_idle", 32'(sout), 32'(0));
        check("done_idle", 32'(done), 32'(0));
      end
      if (sout_valid) begin
        sipo = {sipo[6:0], sout};
        n_valid++;
      end
      if (done) n_done++;
    end
  end

  // Offer a word and hold it until the model says the DUT is ready, then queue its frame.
  task automatic load_word(input logic [Width-1:0] w);
    logic [FrameLen-1:0] frame;
    bit ok;
    ok = 1'b0;
`ifdef PISO_PARITY_EN
    frame = {w, ^w};
`else
    frame = w;
`endif
    load_valid = 1'b1;
    load_data  = w;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (!rst && q.size() == 0) begin
        for (int i = int'(FrameLen) - 1; i >= 0; i--) begin
          q.push_back('{b: frame[i], last: (i == 0)});
        end
        ok = 1'b1;
        break;
      end
    end
    #1;
    load_valid = 1'b0;
    load_data  = '0;
    if (!ok) check("load_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'(0), 32'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    sipo    = '0;
    n_valid = 0;
    n_done  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    // Reset held two cycles with a word offered: nothing may be captured.
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 4'hf;
    @(posedge clk);
    @(posedge clk);
    mon_en = 1'b1;
    #1;
    check("rst_sout", 32'(sout), 32'(0));
    check("rst_sout_valid", 32'(sout_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_load_ready", 32'(load_ready), 32'(1));
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single word, plus loopback into a 4-bit SIPO.
    clear_stats();
    load_word(4'b1011);
    wait_idle();
    check("t2_valid_cycles", n_valid, FrameLen);
    check("t2_done_count", n_done, 32'(1));
`ifdef PISO_PARITY_EN
    check("t6_sipo_parity", 32'(sipo[4:0]), 32'(5'b10111));
`else
    check("t6_sipo", 32'(sipo[3:0]), 32'(4'b1011));
`endif

    // Back-to-back: second word offered immediately, accepted on the last-bit cycle.
    clear_stats();
    load_word(4'b1010);
    load_word(4'b0110);
    wait_idle();
    check("t3_valid_cycles", n_valid, 2 * FrameLen);
    check("t3_done_count", n_done, 32'(2));

    // Word held while busy must wait for the last-bit cycle.
    clear_stats();
    load_word(4'b1100);
    load_word(4'b0011);
    wait_idle();
    check("t4_valid_cycles", n_valid, 2 * FrameLen);
    check("t4_done_count", n_done, 32'(2));

    // Reset after bit 2 aborts the frame with no done pulse.
    clear_stats();
    load_word(4'b1111);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_abort_done", n_done, 32'(0));
    check("t5_abort_valid", n_valid, 32'(2));
    clear_stats();
    load_word(4'b0101);
    wait_idle();
    check("t5_reload_valid", n_valid, FrameLen);
    check("t5_reload_done", n_done, 32'(1));
`ifndef PISO_PARITY_EN
    check("t5_reload_sipo", 32'(sipo[3:0]), 32'(4'b0101));
`endif

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
